// File: rtl/gpio_in_filter_if.sv
// gpio_in_filter_if: pad-side and controller-side signal bundle for gpio_in_filter.
//   gpio_pad    : raw asynchronous pad levels (into filter)
//   edge_clr    : write-one-to-clear for edge_status (into filter)
//   irq_mask    : per-bit interrupt enable (into filter)
//   gpio_filt   : debounced levels (out of filter)
//   rise_pulse  : 1-cycle 0->1 pulse per bit (out of filter)
//   fall_pulse  : 1-cycle 1->0 pulse per bit (out of filter)
//   edge_status : sticky edge-seen flags (out of filter)
//   irq         : OR of edge_status & irq_mask (out of filter)
// master = the environment driving pads/controls, slave = the filter.
interface gpio_in_filter_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] gpio_pad;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] gpio_filt;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] edge_status;
    logic             irq;

    modport master (
        output gpio_pad, edge_clr, irq_mask,
        input  gpio_filt, rise_pulse, fall_pulse, edge_status, irq
    );

    modport slave (
        input  gpio_pad, edge_clr, irq_mask,
        output gpio_filt, rise_pulse, fall_pulse, edge_status, irq
    );
endinterface

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-bit 2-flop synchroniser, stability-counter debounce and
// edge detection in front of the GPIO controller's gpio_in bus.
// Ports:
//   sys_clk : system clock, all state on rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : gpio_in_filter_if.slave (pads, clears, mask in; levels, pulses, status, irq out)
// Optional feature macro GPIO_FILT_IRQ_EN: when defined, sticky edge_status and a
// registered irq are built; otherwise edge_status/irq are tied to 0 and
// edge_clr/irq_mask are ignored.
module gpio_in_filter #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    gpio_in_filter_if.slave  bus
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_filt_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;

    // Synchroniser chain; sync1 feeds nothing but sync2.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.gpio_pad;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a mismatch must persist DEBOUNCE_CYCLES cycles before acceptance.
    always_comb begin
        w_filt_nxt = r_filt;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_filt[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_filt_nxt[i] = r_sync2[i];
                    w_rise_nxt[i] = r_sync2[i];
                    w_fall_nxt[i] = ~r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Filtered level, edge pulses and counters.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= '0;
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_filt <= w_filt_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign bus.gpio_filt  = r_filt;
    assign bus.rise_pulse = r_rise;
    assign bus.fall_pulse = r_fall;

`ifdef GPIO_FILT_IRQ_EN
    logic [WIDTH-1:0] r_edge_status;
    logic             r_irq;
    logic [WIDTH-1:0] w_status_nxt;

    // Set beats clear when both land on the same cycle.
    assign w_status_nxt = (r_edge_status & ~bus.edge_clr) | r_rise | r_fall;

    // irq is computed from the next status so it tracks status edge for edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_status <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_edge_status <= w_status_nxt;
            r_irq         <= |(w_status_nxt & bus.irq_mask);
        end
    end

    assign bus.edge_status = r_edge_status;
    assign bus.irq         = r_irq;
`else
    logic w_unused;

    assign w_unused        = ^{bus.edge_clr, bus.irq_mask};
    assign bus.edge_status = '0;
    assign bus.irq         = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: directed scenarios plus randomized pad/clear/mask traffic
// for gpio_in_filter (WIDTH=32, DEBOUNCE_CYCLES=4), checked against a
// window-based reference model and explicit expected values.
module tb_gpio_in_filter;

    localparam int unsigned W   = 32;
    localparam int          DEB = 4;
`ifdef GPIO_FILT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam int VW = 4 * W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    gpio_in_filter_if #(.WIDTH(W)) bus ();

    gpio_in_filter #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial forever #10 clk = ~clk;

    // Reference model: a level is accepted when the last DEB synchronised
    // samples (pad delayed by two sampling edges) all disagree with it.
    logic [W-1:0] hist [0:DEB];
    logic [W-1:0] m_filt = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    logic [W-1:0] m_es   = '0;
    logic         m_irq  = 1'b0;
    logic [W-1:0] nr, nf, es_n;
    bit           stable;

    initial begin
        for (int j = 0; j <= DEB; j++) hist[j] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int j = 0; j <= DEB; j++) hist[j] = '0;
                m_filt = '0; m_rise = '0; m_fall = '0; m_es = '0; m_irq = 1'b0;
            end else begin
                es_n  = IRQ_ON ? ((m_es & ~bus.edge_clr) | m_rise | m_fall) : '0;
                m_irq = IRQ_ON ? |(es_n & bus.irq_mask) : 1'b0;
                m_es  = es_n;
                for (int i = 0; i < int'(W); i++) begin
                    stable = 1'b1;
                    for (int j = 1; j <= DEB; j++)
                        if (hist[j][i] == m_filt[i]) stable = 1'b0;
                    nr[i] = stable & ~m_filt[i];
                    nf[i] = stable & m_filt[i];
                end
                m_rise = nr;
                m_fall = nf;
                m_filt = m_filt ^ (nr | nf);
                for (int j = DEB; j >= 1; j--) hist[j] = hist[j-1];
                hist[0] = bus.gpio_pad;
            end
        end
    end

    function automatic logic [VW-1:0] dut_vec();
        return {bus.gpio_filt, bus.rise_pulse, bus.fall_pulse, bus.edge_status, bus.irq};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_filt, m_rise, m_fall, m_es, m_irq};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL reset_hold act=%h exp=0", dut_vec());
        end
        #5 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (dut_vec() !== '0) begin
                failures++;
                $display("FAIL reset_idle c=%0d act=%h exp=0", c, dut_vec());
            end
        end
    endtask

    task automatic test_pattern();
        logic [W-1:0] ef, er;
        bus.gpio_pad = 32'h90abcdef;
        for (int c = 1; c <= 7; c++) begin
            step();
            ef = (c >= 6) ? 32'h90abcdef : '0;
            er = (c == 6) ? 32'h90abcdef : '0;
            checks++;
            if (bus.gpio_filt !== ef) begin
                failures++;
                $display("FAIL pattern_filt c=%0d act=%h exp=%h", c, bus.gpio_filt, ef);
            end
            checks++;
            if (bus.rise_pulse !== er) begin
                failures++;
                $display("FAIL pattern_rise c=%0d act=%h exp=%h", c, bus.rise_pulse, er);
            end
            checks++;
            if (bus.fall_pulse !== '0) begin
                failures++;
                $display("FAIL pattern_fall c=%0d act=%h exp=0", c, bus.fall_pulse);
            end
        end
        bus.gpio_pad = '0;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL pattern_model c=%0d act=%h exp=%h", c, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_glitch();
        bus.gpio_pad = 32'h1;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 3) bus.gpio_pad = '0;
            checks++;
            if ({bus.gpio_filt[0], bus.rise_pulse[0], bus.fall_pulse[0]} !== 3'b000) begin
                failures++;
                $display("FAIL glitch_short c=%0d act=%b exp=000", c,
                         {bus.gpio_filt[0], bus.rise_pulse[0], bus.fall_pulse[0]});
            end
        end
        bus.gpio_pad = 32'h1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 4) bus.gpio_pad = '0;
            checks++;
            if ({bus.gpio_filt[0], bus.rise_pulse[0], bus.fall_pulse[0]} !==
                {(c >= 6 && c <= 9), (c == 6), (c == 10)}) begin
                failures++;
                $display("FAIL glitch_min c=%0d act=%b exp=%b", c,
                         {bus.gpio_filt[0], bus.rise_pulse[0], bus.fall_pulse[0]},
                         {(c >= 6 && c <= 9), (c == 6), (c == 10)});
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL glitch_model c=%0d act=%h exp=%h", c, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.gpio_pad = 32'h1;
        for (int c = 1; c <= 3; c++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL rstmid_assert act=%h exp=0", dut_vec());
        end
        for (int c = 1; c <= 2; c++) begin
            step();
            checks++;
            if (dut_vec() !== '0) begin
                failures++;
                $display("FAIL rstmid_hold c=%0d act=%h exp=0", c, dut_vec());
            end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if ({bus.gpio_filt, bus.rise_pulse} !== {32'(c >= 6), 32'(c == 6)}) begin
                failures++;
                $display("FAIL rstmid_rise c=%0d filt=%h rise=%h exp_filt=%h exp_rise=%h", c,
                         bus.gpio_filt, bus.rise_pulse, 32'(c >= 6), 32'(c == 6));
            end
        end
    endtask

    task automatic test_irq();
        bus.gpio_pad = '0;
        for (int c = 1; c <= 8; c++) step();
        bus.edge_clr = '1;
        step();
        bus.edge_clr = '0;
        bus.irq_mask = 32'h1;
        bus.gpio_pad = 32'h1;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if ({bus.edge_status[0], bus.irq} !== {2{IRQ_ON && c >= 7}}) begin
                failures++;
                $display("FAIL irq_set c=%0d act=%b exp=%b", c,
                         {bus.edge_status[0], bus.irq}, {2{IRQ_ON && c >= 7}});
            end
        end
        bus.edge_clr = 32'h1;
        step();
        bus.edge_clr = '0;
        checks++;
        if ({bus.edge_status, bus.irq} !== '0) begin
            failures++;
            $display("FAIL irq_clear act=%h exp=0", {bus.edge_status, bus.irq});
        end
        bus.edge_clr = 32'h1;
        bus.gpio_pad = '0;
        for (int c = 1; c <= 7; c++) begin
            step();
            checks++;
            if ({bus.edge_status[0], bus.irq} !== {2{IRQ_ON && c == 7}}) begin
                failures++;
                $display("FAIL irq_setwins c=%0d act=%b exp=%b", c,
                         {bus.edge_status[0], bus.irq}, {2{IRQ_ON && c == 7}});
            end
        end
        bus.edge_clr = '0;
        step();
        checks++;
        if ({bus.edge_status[0], bus.irq} !== {2{IRQ_ON}}) begin
            failures++;
            $display("FAIL irq_sticky act=%b exp=%b", {bus.edge_status[0], bus.irq}, {2{IRQ_ON}});
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL irq_model act=%h exp=%h", dut_vec(), model_vec());
        end
        bus.edge_clr = '1;
        step();
        bus.edge_clr = '0;
        bus.irq_mask = '0;
    endtask

    task automatic test_all_fall();
        bus.gpio_pad = '1;
        for (int c = 1; c <= 8; c++) step();
        bus.gpio_pad = '0;
        for (int c = 1; c <= 7; c++) begin
            step();
            checks++;
            if ({bus.fall_pulse, bus.rise_pulse} !== {(c == 6) ? 32'hffffffff : 32'h0, 32'h0}) begin
                failures++;
                $display("FAIL all_fall c=%0d fall=%h rise=%h", c, bus.fall_pulse, bus.rise_pulse);
            end
        end
    endtask

    task automatic test_random();
        bus.irq_mask = $urandom;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0)
                bus.gpio_pad = bus.gpio_pad ^ ($urandom & $urandom & $urandom);
            bus.edge_clr = $urandom & $urandom & $urandom;
            if (c % 150 == 0) bus.irq_mask = $urandom;
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL random_model c=%0d act=%h exp=%h", c, dut_vec(), model_vec());
            end
            checks++;
            if ((bus.rise_pulse & bus.fall_pulse) !== '0) begin
                failures++;
                $display("FAIL random_excl c=%0d act=%h exp=0", c, bus.rise_pulse & bus.fall_pulse);
            end
        end
    endtask

    initial begin
        bus.gpio_pad = '0;
        bus.edge_clr = '0;
        bus.irq_mask = '0;
        #95;
        test_reset();
        test_pattern();
        test_glitch();
        test_reset_mid();
        test_irq();
        test_all_fall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
